std_mem_d1_arbiter: RTL



---
 rtl/std_arb_pkg.sv | 15 +
 rtl/std_rr_picker.sv | 28 ++
 rtl/std_mem_d1_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/std_arb_pkg.sv
// Shared types and sizing helpers for the round-robin memory arbiter.
package std_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT_WR,
    DONE
  } state_t;

  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 2) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/std_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module std_rr_picker
  import std_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned GW = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      rr_ptr,
  output logic               valid,
  output logic [GW-1:0]      grant
);

  always_comb begin
    int unsigned idx;
    valid = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/std_mem_d1_arbiter.sv
// Round-robin arbiter serialising NUM_REQ go/done requesters onto one std_mem_d1.
module std_mem_d1_arbiter
  import std_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned IDX_SIZE = 4,
  parameter int unsigned NUM_REQ  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_go,
  input  logic [NUM_REQ-1:0]          req_write_en,
  input  logic [NUM_REQ*IDX_SIZE-1:0] req_addr0,
  input  logic [NUM_REQ*WIDTH-1:0]    req_write_data,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [WIDTH-1:0]            req_read_data,
  output logic [IDX_SIZE-1:0]         mem_addr0,
  output logic [WIDTH-1:0]            mem_write_data,
  output logic                        mem_write_en,
  input  logic [WIDTH-1:0]            mem_read_data,
  input  logic                        mem_done
);

  localparam int unsigned GW = grant_width(NUM_REQ);

  state_t            state, state_next;
  logic [GW-1:0]     g, rr_ptr, pick;
  logic              pick_valid;
  logic [WIDTH-1:0]  rd_q;
  logic [IDX_SIZE-1:0] addr_arr [NUM_REQ];
  logic [WIDTH-1:0]    data_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr0[i*IDX_SIZE +: IDX_SIZE];
      data_arr[i] = req_write_data[i*WIDTH +: WIDTH];
    end
  end

  std_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req_go),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .grant  (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    mem_addr0      = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    req_done       = '0;
    case (state)
      IDLE: if (pick_valid) state_next = ACCESS;
      ACCESS: begin
        mem_addr0      = addr_arr[g];
        mem_write_data = data_arr[g];
        if (req_write_en[g]) begin
          mem_write_en = 1'b1;
          state_next   = WAIT_WR;
        end else begin
          state_next = DONE;
        end
      end
      WAIT_WR: begin
        mem_addr0      = addr_arr[g];
        mem_write_data = data_arr[g];
        if (mem_done) state_next = DONE;
      end
      DONE: begin
        req_done[g] = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant, pointer and read capture only move on the FSM's own transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      g      <= '0;
      rr_ptr <= '0;
      rd_q   <= '0;
    end else begin
      if (state == IDLE && pick_valid) g <= pick;
      if (state == ACCESS && !req_write_en[g]) rd_q <= mem_read_data;
      if (state == DONE) rr_ptr <= (g == GW'(NUM_REQ - 1)) ? '0 : g + GW'(1);
    end
  end

  assign req_read_data = rd_q;

endmodule
